iitb_multicycle_core: RTL

- Multi-cycle IITB-RISC core: executes one instruction over several cycles through a single shared memory port with a req/ack handshake, so memory can insert wait states.
- Successor to the single-cycle processor top.
- Sits between the system memory/peripheral fabric and debug logic.
- Adds parametrised reset vector and address width, wait-state tolerance, a HALT opcode and retire/halt status.

---
 rtl/iitb_mc_pkg.sv | 70 +++++++
 rtl/iitb_multicycle_core_regfile.sv | 35 +++
 rtl/iitb_multicycle_core.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/iitb_mc_pkg.sv
// Shared definitions for the multi-cycle IITB-RISC core: opcodes, CZ
// conditions, FSM state encoding, instruction field positions and helpers.
package iitb_mc_pkg;

  localparam int DATA_W = 16;
  localparam int RF_N   = 8;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_BEQ = 4'b1100;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // CZ field of ADD/NDU; 11 behaves like 00
  localparam logic [1:0] CZ_ALWAYS  = 2'b00;
  localparam logic [1:0] CZ_IF_Z    = 2'b01;
  localparam logic [1:0] CZ_IF_C    = 2'b10;
  localparam logic [1:0] CZ_ALWAYS2 = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int RA_HI   = 11;
  localparam int RA_LO   = 9;
  localparam int RB_HI   = 8;
  localparam int RB_LO   = 6;
  localparam int RC_HI   = 5;
  localparam int RC_LO   = 3;
  localparam int CZ_HI   = 1;
  localparam int CZ_LO   = 0;
  localparam int IMM6_HI = 5;
  localparam int IMM6_LO = 0;
  localparam int IMM9_HI = 8;
  localparam int IMM9_LO = 0;

  function automatic logic [DATA_W-1:0] sext6(input logic [5:0] v);
    return {{(DATA_W-6){v[5]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] sext9(input logic [8:0] v);
    return {{(DATA_W-9){v[8]}}, v};
  endfunction

  // Whether a conditional ADD/NDU is allowed to commit given current flags
  function automatic logic cz_pass(input logic [1:0] cz, input logic c, input logic z);
    logic ok;
    case (cz)
      CZ_IF_C:    ok = c;
      CZ_IF_Z:    ok = z;
      CZ_ALWAYS:  ok = 1'b1;
      CZ_ALWAYS2: ok = 1'b1;
      default:    ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/iitb_multicycle_core_regfile.sv
// 8x16 general-purpose register file: two asynchronous read ports, one
// synchronous write port, all registers cleared by the async reset.
module mc_regfile
  import iitb_mc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           ra_addr,
  output logic [DATA_W-1:0]    ra_data,
  input  logic [2:0]           rb_addr,
  output logic [DATA_W-1:0]    rb_data,
  input  logic                 we,
  input  logic [2:0]           wa,
  input  logic [DATA_W-1:0]    wd
);

  logic [RF_N-1:0][DATA_W-1:0] regs_q;
  logic [RF_N-1:0][DATA_W-1:0] regs_d;

  // Next register contents: hold, or replace the addressed entry on write
  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[wa] = wd;
  end

  // Register storage with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  assign ra_data = regs_q[ra_addr];
  assign rb_data = regs_q[rb_addr];

endmodule

// File: rtl/iitb_multicycle_core.sv
// Multi-cycle IITB-RISC core. One instruction walks FETCH/DECODE/EXEC and
// then MEM and/or WB over a single req/ack memory port that may stall.
// Every output is decoded from registered state, so mem_ack never reaches
// an output combinationally; retire is therefore a registered pulse that
// appears in the cycle after the instruction's final state.
module iitb_multicycle_core #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              retire,
  output logic              halted,
  output logic [15:0]       dbg_pc
);
  import iitb_mc_pkg::*;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] imm6_q, imm6_d;
  logic [15:0] imm9_q, imm9_d;
  logic [15:0] y_q, y_d;
  logic [15:0] npc_q, npc_d;
  logic        c_q, c_d;
  logic        z_q, z_d;
  logic        cn_q, cn_d;
  logic        setc_q, setc_d;
  logic        setz_q, setz_d;
  logic        wr_q, wr_d;
  logic [2:0]  wa_q, wa_d;
  logic        retire_q, retire_d;

  logic [3:0]  op;
  logic [2:0]  ra_f, rb_f, rc_f;
  logic [1:0]  cz_f;
  logic [15:0] rf_a, rf_b;
  logic        rf_we;
  logic [16:0] sum;

  assign op   = ir_q[OP_HI:OP_LO];
  assign ra_f = ir_q[RA_HI:RA_LO];
  assign rb_f = ir_q[RB_HI:RB_LO];
  assign rc_f = ir_q[RC_HI:RC_LO];
  assign cz_f = ir_q[CZ_HI:CZ_LO];

  assign rf_we = (state_q == ST_WB) && wr_q;

  mc_regfile u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (ra_f),
    .ra_data (rf_a),
    .rb_addr (rb_f),
    .rb_data (rf_b),
    .we      (rf_we),
    .wa      (wa_q),
    .wd      (y_q)
  );

  // State and datapath registers, all cleared by the async reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm6_q   <= '0;
      imm9_q   <= '0;
      y_q      <= '0;
      npc_q    <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      cn_q     <= 1'b0;
      setc_q   <= 1'b0;
      setz_q   <= 1'b0;
      wr_q     <= 1'b0;
      wa_q     <= '0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      imm6_q   <= imm6_d;
      imm9_q   <= imm9_d;
      y_q      <= y_d;
      npc_q    <= npc_d;
      c_q      <= c_d;
      z_q      <= z_d;
      cn_q     <= cn_d;
      setc_q   <= setc_d;
      setz_q   <= setz_d;
      wr_q     <= wr_d;
      wa_q     <= wa_d;
      retire_q <= retire_d;
    end
  end

  // Next-state logic: sequencing, ALU, branch targets and commit
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    imm6_d   = imm6_q;
    imm9_d   = imm9_q;
    y_d      = y_q;
    npc_d    = npc_q;
    c_d      = c_q;
    z_d      = z_q;
    cn_d     = cn_q;
    setc_d   = setc_q;
    setz_d   = setz_q;
    wr_d     = wr_q;
    wa_d     = wa_q;
    retire_d = 1'b0;
    sum      = '0;

    case (state_q)
      ST_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        a_d     = rf_a;
        b_d     = rf_b;
        imm6_d  = sext6(ir_q[IMM6_HI:IMM6_LO]);
        imm9_d  = sext9(ir_q[IMM9_HI:IMM9_LO]);
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        // Commit controls are decided here so WB only applies them
        npc_d  = pc_q + 16'd1;
        y_d    = '0;
        cn_d   = c_q;
        wr_d   = 1'b0;
        setc_d = 1'b0;
        setz_d = 1'b0;
        wa_d   = ra_f;
        case (op)
          OP_ADD: begin
            sum  = {1'b0, a_q} + {1'b0, b_q};
            y_d  = sum[15:0];
            cn_d = sum[16];
            wa_d = rc_f;
            if (cz_pass(cz_f, c_q, z_q)) begin
              wr_d   = 1'b1;
              setc_d = 1'b1;
              setz_d = 1'b1;
            end
          end
          OP_ADI: begin
            sum    = {1'b0, a_q} + {1'b0, imm6_q};
            y_d    = sum[15:0];
            cn_d   = sum[16];
            wa_d   = rb_f;
            wr_d   = 1'b1;
            setc_d = 1'b1;
            setz_d = 1'b1;
          end
          OP_NDU: begin
            y_d  = ~(a_q & b_q);
            wa_d = rc_f;
            if (cz_pass(cz_f, c_q, z_q)) begin
              wr_d   = 1'b1;
              setz_d = 1'b1;
            end
          end
          OP_LHI: begin
            y_d  = {imm9_q[8:0], 7'b0};
            wr_d = 1'b1;
          end
          OP_LW: begin
            y_d    = b_q + imm6_q;
            wr_d   = 1'b1;
            setz_d = 1'b1;
          end
          OP_SW: begin
            y_d = b_q + imm6_q;
          end
          OP_BEQ: begin
            if (a_q == b_q) npc_d = pc_q + imm6_q;
          end
          OP_JAL: begin
            y_d   = pc_q + 16'd1;
            wr_d  = 1'b1;
            npc_d = pc_q + imm9_q;
          end
          OP_JLR: begin
            // b_q was captured before this write, so RA==RB jumps to the old value
            y_d   = pc_q + 16'd1;
            wr_d  = 1'b1;
            npc_d = b_q;
          end
          default: ;
        endcase
        if (op == OP_LW || op == OP_SW) state_d = ST_MEM;
        else if (op == OP_HLT)          state_d = ST_HALT;
        else                            state_d = ST_WB;
      end

      ST_MEM: begin
        if (mem_ack) begin
          if (op == OP_LW) begin
            y_d     = mem_rdata;
            state_d = ST_WB;
          end else begin
            pc_d     = npc_q;
            retire_d = 1'b1;
            state_d  = ST_FETCH;
          end
        end
      end

      ST_WB: begin
        // Z is taken from the committed value, which for LW is the loaded word
        pc_d     = npc_q;
        if (setc_q) c_d = cn_q;
        if (setz_q) z_d = (y_q == 16'h0000);
        retire_d = 1'b1;
        state_d  = ST_FETCH;
      end

      ST_HALT: ;

      default: state_d = ST_FETCH;
    endcase
  end

  // Memory port and status outputs decoded from registered state only
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q[ADDR_W-1:0];
    mem_wdata = '0;
    halted    = 1'b0;
    case (state_q)
      ST_FETCH: mem_req = 1'b1;
      ST_MEM: begin
        mem_req  = 1'b1;
        mem_addr = y_q[ADDR_W-1:0];
        if (op == OP_SW) begin
          mem_we    = 1'b1;
          mem_wdata = a_q;
        end
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign retire = retire_q;
  assign dbg_pc = pc_q;

endmodule
